// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Logic, arithmetic, shift and compare ops finish in
// one cycle. Unsigned multiply, divide and remainder iterate one bit per cycle
// for WIDTH cycles. Valid/ready handshakes on both the operand and result sides.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  // a_q: multiplicand (shifts left) or dividend/quotient (shifts left, quotient bits enter at bit 0)
  // b_q: multiplier (shifts right) or divisor (constant)
  // acc_q: partial product or partial remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quickRes;
  logic             isIter;
  logic [WIDTH-1:0] mulSum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             qBit;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quotNext;
  logic [WIDTH-1:0] finalRes;

  // Single-cycle result, computed straight from the operand inputs at accept time
  always_comb begin
    shamt    = in1[SHW-1:0];
    quickRes = '0;
    case (ALUCtrl)
      OP_AND:  quickRes = in0 & in1;
      OP_OR:   quickRes = in0 | in1;
      OP_ADD:  quickRes = in0 + in1;
      OP_XOR:  quickRes = in0 ^ in1;
      OP_SLL:  quickRes = in0 << shamt;
      OP_SRL:  quickRes = in0 >> shamt;
      OP_SUB:  quickRes = in0 - in1;
      OP_SLTU: quickRes = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      OP_SLT:  quickRes = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      OP_NOR:  quickRes = ~(in0 | in1);
      OP_SRA:  quickRes = $signed(in0) >>> shamt;
      default: quickRes = '0;
    endcase
    isIter = (ALUCtrl == OP_MUL) || (ALUCtrl == OP_DIVU) || (ALUCtrl == OP_REMU);
  end

  // One iteration step of shift-add multiply and restoring division.
  // With a zero divisor every trial subtraction succeeds, so the quotient
  // fills with ones and the remainder ends up equal to the dividend.
  always_comb begin
    mulSum   = acc_q + (b_q[0] ? a_q : '0);
    trial    = {acc_q, a_q[WIDTH-1]};
    qBit     = (trial >= {1'b0, b_q});
    diff     = trial[WIDTH-1:0] - b_q;
    remNext  = qBit ? diff : trial[WIDTH-1:0];
    quotNext = {a_q[WIDTH-2:0], qBit};
    case (op_q)
      OP_MUL:  finalRes = mulSum;
      OP_DIVU: finalRes = quotNext;
      default: finalRes = remNext;
    endcase
  end

  // Next-state logic for the control FSM and the datapath registers
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          op_d = ALUCtrl;
          if (isIter) begin
            a_d     = in0;
            b_d     = in1;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = BUSY;
          end else begin
            result_d = quickRes;
            zero_d   = (quickRes == '0);
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (op_q == OP_MUL) begin
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          acc_d = mulSum;
        end else begin
          a_d   = quotNext;
          acc_d = remNext;
        end
        if (cnt_q == '0) begin
          result_d = finalRes;
          zero_d   = (finalRes == '0);
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign ALUOut   = result_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed tests for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

  logic        clk;
  logic        rst;

  logic        inValid, inReady, outValid, outReady, zero;
  logic [31:0] a0, a1, aluOut;
  logic [3:0]  ctrl;

  logic        inValid8, inReady8, outValid8, outReady8, zero8;
  logic [7:0]  b0, b1, aluOut8;
  logic [3:0]  ctrl8;

  int checks;
  int errors;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InValid(inValid), .InReady(inReady),
    .in0(a0), .in1(a1), .ALUCtrl(ctrl), .OutValid(outValid),
    .OutReady(outReady), .ALUOut(aluOut), .Zero(zero)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .InValid(inValid8), .InReady(inReady8),
    .in0(b0), .in1(b1), .ALUCtrl(ctrl8), .OutValid(outValid8),
    .OutReady(outReady8), .ALUOut(aluOut8), .Zero(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle vectors, WIDTH=32
  localparam int NS32 = 15;
  logic [3:0]  s32Op  [NS32] = '{4'b0010, 4'b0110, 4'b1111, 4'b0000, 4'b0001,
                                 4'b0011, 4'b1100, 4'b1101, 4'b0101, 4'b1000,
                                 4'b0111, 4'b0100, 4'b0110, 4'b0010, 4'b1110};
  logic [31:0] s32A   [NS32] = '{32'd5, 32'd3, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd9};
  logic [31:0] s32B   [NS32] = '{32'd7, 32'd3, 32'd7, 32'hFF00FF00, 32'hFF00FF00,
                                 32'hFF00FF00, 32'hFF00FF00, 32'd4, 32'd4, 32'd1,
                                 32'd1, 32'd33, 32'd1, 32'd1, 32'd9};
  logic [31:0] s32Exp [NS32] = '{32'd12, 32'd0, 32'd0, 32'hF000F000, 32'hFFF0FFF0,
                                 32'h0FF00FF0, 32'h000F000F, 32'hF8000000, 32'h08000000, 32'd1,
                                 32'd0, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};

  // Iterative vectors, WIDTH=32
  localparam int NI32 = 6;
  logic [3:0]  i32Op  [NI32] = '{4'b1001, 4'b1001, 4'b1010, 4'b1011, 4'b1010, 4'b1011};
  logic [31:0] i32A   [NI32] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd5, 32'd5};
  logic [31:0] i32B   [NI32] = '{32'h0000FFFF, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
  logic [31:0] i32Exp [NI32] = '{32'hFFFE0001, 32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};

  // Vectors for WIDTH=8 (first 8 single-cycle, last 6 iterative)
  localparam int N8 = 14;
  logic [3:0]  v8Op  [N8] = '{4'b0010, 4'b0110, 4'b1111, 4'b1101, 4'b0101, 4'b1000, 4'b0111,
                              4'b0100, 4'b1001, 4'b1001, 4'b1010, 4'b1011, 4'b1010, 4'b1011};
  logic [7:0]  v8A   [N8] = '{8'd5, 8'd3, 8'd5, 8'h80, 8'h80, 8'hFF, 8'hFF,
                              8'd1, 8'h0F, 8'hFF, 8'd100, 8'd100, 8'd5, 8'd5};
  logic [7:0]  v8B   [N8] = '{8'd7, 8'd3, 8'd7, 8'd4, 8'd4, 8'd1, 8'd1,
                              8'd9, 8'h0F, 8'd2, 8'd7, 8'd7, 8'd0, 8'd0};
  logic [7:0]  v8Exp [N8] = '{8'd12, 8'd0, 8'd0, 8'hF8, 8'h08, 8'd1, 8'd0,
                              8'd2, 8'hE1, 8'hFE, 8'd14, 8'd2, 8'hFF, 8'd5};
  int          v8Lat [N8] = '{1, 1, 1, 1, 1, 1, 1, 1, 9, 9, 9, 9, 9, 9};

  // Issue one op on the 32-bit DUT, wait for the result, take it.
  // lat = 1 at the first falling edge after the accepting rising edge.
  task automatic run32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output logic z,
                       output logic readySeen);
    @(negedge clk);
    ctrl = op; a0 = x; a1 = y; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    readySeen = 1'b0;
    while (!outValid && lat < 200) begin
      if (inReady) readySeen = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = aluOut;
    z = zero;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output logic [7:0] res, output logic z);
    @(negedge clk);
    ctrl8 = op; b0 = x; b1 = y; inValid8 = 1'b1;
    @(negedge clk);
    inValid8 = 1'b0;
    lat = 1;
    while (!outValid8 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = aluOut8;
    z = zero8;
    outReady8 = 1'b1;
    @(negedge clk);
    outReady8 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset InReady got %b want 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset OutValid got %b want 0", outValid); end
    checks++; if (aluOut !== 32'd0) begin errors++; $display("[TB] FAIL reset ALUOut got %h want 0", aluOut); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL reset Zero got %b want 1", zero); end
    checks++; if (inReady8 !== 1'b1) begin errors++; $display("[TB] FAIL reset8 InReady got %b want 1", inReady8); end
    checks++; if (outValid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset8 OutValid got %b want 0", outValid8); end
    checks++; if (aluOut8 !== 8'd0) begin errors++; $display("[TB] FAIL reset8 ALUOut got %h want 0", aluOut8); end
    checks++; if (zero8 !== 1'b1) begin errors++; $display("[TB] FAIL reset8 Zero got %b want 1", zero8); end
  endtask

  task automatic test_single_cycle();
    int lat; logic [31:0] res; logic z, rs;
    for (int i = 0; i < NS32; i++) begin
      run32(s32Op[i], s32A[i], s32B[i], lat, res, z, rs);
      checks++; if (res !== s32Exp[i]) begin errors++; $display("[TB] FAIL single[%0d] ALUOut got %h want %h", i, res, s32Exp[i]); end
      checks++; if (z !== (s32Exp[i] == 32'd0)) begin errors++; $display("[TB] FAIL single[%0d] Zero got %b want %b", i, z, (s32Exp[i] == 32'd0)); end
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL single[%0d] latency got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_iterative();
    int lat; logic [31:0] res; logic z, rs;
    for (int i = 0; i < NI32; i++) begin
      run32(i32Op[i], i32A[i], i32B[i], lat, res, z, rs);
      checks++; if (res !== i32Exp[i]) begin errors++; $display("[TB] FAIL iter[%0d] ALUOut got %h want %h", i, res, i32Exp[i]); end
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL iter[%0d] Zero got %b want 0", i, z); end
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL iter[%0d] latency got %0d want 33", i, lat); end
      checks++; if (rs !== 1'b0) begin errors++; $display("[TB] FAIL iter[%0d] InReady seen high while busy got %b want 0", i, rs); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ctrl = 4'b0010; a0 = 32'd1; a1 = 32'd1; inValid = 1'b1;
    @(negedge clk);
    ctrl = 4'b0110; a0 = 32'd9; a1 = 32'd4;
    for (int i = 0; i < 10; i++) begin
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL hold[%0d] OutValid got %b want 1", i, outValid); end
      checks++; if (aluOut !== 32'd2) begin errors++; $display("[TB] FAIL hold[%0d] ALUOut got %h want 2", i, aluOut); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL hold[%0d] InReady got %b want 0", i, inReady); end
      @(negedge clk);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL release OutValid got %b want 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL release InReady got %b want 1", inReady); end
    checks++; if (aluOut !== 32'd2) begin errors++; $display("[TB] FAIL release ALUOut got %h want 2", aluOut); end
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [31:0] res; logic z, rs;
    @(negedge clk);
    ctrl = 4'b1010; a0 = 32'd1000; a1 = 32'd3; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL midbusy InReady got %b want 0", inReady); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL abort OutValid got %b want 0", outValid); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL abort InReady got %b want 1", inReady); end
    checks++; if (aluOut !== 32'd0) begin errors++; $display("[TB] FAIL abort ALUOut got %h want 0", aluOut); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL abort Zero got %b want 1", zero); end
    run32(4'b0010, 32'd2, 32'd2, lat, res, z, rs);
    checks++; if (res !== 32'd4) begin errors++; $display("[TB] FAIL after-abort ALUOut got %h want 4", res); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL after-abort latency got %0d want 1", lat); end
  endtask

  task automatic test_width8();
    int lat; logic [7:0] res; logic z;
    for (int i = 0; i < N8; i++) begin
      run8(v8Op[i], v8A[i], v8B[i], lat, res, z);
      checks++; if (res !== v8Exp[i]) begin errors++; $display("[TB] FAIL w8[%0d] ALUOut got %h want %h", i, res, v8Exp[i]); end
      checks++; if (z !== (v8Exp[i] == 8'd0)) begin errors++; $display("[TB] FAIL w8[%0d] Zero got %b want %b", i, z, (v8Exp[i] == 8'd0)); end
      checks++; if (lat !== v8Lat[i]) begin errors++; $display("[TB] FAIL w8[%0d] latency got %0d want %0d", i, lat, v8Lat[i]); end
    end
  endtask

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    inValid = 1'b0; outReady = 1'b0; a0 = '0; a1 = '0; ctrl = '0;
    inValid8 = 1'b0; outReady8 = 1'b0; b0 = '0; b1 = '0; ctrl8 = '0;
    test_reset();
    test_single_cycle();
    test_iterative();
    test_backpressure();
    test_reset_mid_busy();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
